// File: rtl/dal_interval_mode_if.sv
// Score-in / result-out bundle of the DAL interval/mode unit.
// Score side: a sample moves when s_valid_i && s_ready_o at a rising edge; result side: a result moves when m_valid_o && m_ready_i.
interface dal_interval_mode_if #(
    parameter int SCORE_W = 16,
    parameter int NUM_INT = 16,
    parameter int CNT_W   = 12,
    parameter int ACC_W   = 20
);
    localparam int IDX_W = $clog2(NUM_INT);

    logic               clear_i;
    logic               s_valid_i;
    logic               s_ready_o;
    logic [SCORE_W-1:0] score_i;
    logic               last_i;
    logic               m_valid_o;
    logic               m_ready_i;
    logic [IDX_W-1:0]   mode_o;
    logic [CNT_W-1:0]   max_cnt_o;
    logic [CNT_W-1:0]   left_cnt_o;
    logic [CNT_W-1:0]   right_cnt_o;
    logic [ACC_W-1:0]   acc_interval_o;
    logic               busy_o;

    modport slave (
        input  clear_i, s_valid_i, score_i, last_i, m_ready_i,
        output s_ready_o, m_valid_o, mode_o, max_cnt_o, left_cnt_o, right_cnt_o,
               acc_interval_o, busy_o
    );

    modport master (
        output clear_i, s_valid_i, score_i, last_i, m_ready_i,
        input  s_ready_o, m_valid_o, mode_o, max_cnt_o, left_cnt_o, right_cnt_o,
               acc_interval_o, busy_o
    );
endinterface

// File: rtl/dal_interval_mode_unit.sv
// Histograms a score stream into NUM_INT equal bins, then scans for the mode bin and
// reports mode index, its count, its neighbours' counts and the block total.
module dal_interval_mode_unit #(
    parameter int SCORE_W = 16,
    parameter int NUM_INT = 16,
    parameter int CNT_W   = 12,
    parameter int ACC_W   = 20
) (
    input  logic                CLK_i,
    input  logic                RST_i,
    dal_interval_mode_if.slave  bus,
    output logic [1:0]          state_dbg
);
    localparam int IDX_W = $clog2(NUM_INT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INT - 1);

    typedef enum logic [1:0] {ACCUM, SCAN, NEIGH, OUT} state_t;

    state_t             state, state_nxt;
    logic               run;
    logic [CNT_W-1:0]   cnt [NUM_INT];
    logic [ACC_W-1:0]   total;
    logic [IDX_W-1:0]   scan_idx, best_idx, idx;
    logic [CNT_W-1:0]   best_cnt;
    logic               take, drain, flush;
    logic               unused_score_low;

    assign idx              = bus.score_i[SCORE_W-1 -: IDX_W];
    assign unused_score_low = ^bus.score_i[SCORE_W-IDX_W-1:0];

    // run keeps s_ready_o low while reset is held, even though ACCUM is the reset state
    assign bus.s_ready_o = run && (state == ACCUM);
    assign bus.busy_o    = (state != ACCUM);
    assign state_dbg     = state;

    assign take  = bus.s_valid_i && bus.s_ready_o && !bus.clear_i;
    assign drain = (state == OUT) && bus.m_ready_i;
    assign flush = bus.clear_i || drain;

    always_ff @(posedge CLK_i or negedge RST_i) begin
        if (!RST_i) begin
            state <= ACCUM;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (take && bus.last_i) state_nxt = SCAN;
            SCAN:  if (scan_idx == LAST_IDX) state_nxt = NEIGH;
            NEIGH: state_nxt = OUT;
            OUT:   if (bus.m_ready_i) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
        if (bus.clear_i) state_nxt = ACCUM;
    end

    always_ff @(posedge CLK_i or negedge RST_i) begin
        if (!RST_i) begin
            for (int i = 0; i < NUM_INT; i++) cnt[i] <= '0;
            total <= '0;
        end else begin
            for (int i = 0; i < NUM_INT; i++) begin
                if (flush) begin
                    cnt[i] <= '0;
                end else if (take && idx == IDX_W'(i) && cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            if (flush) begin
                total <= '0;
            end else if (take && total != ACC_MAX) begin
                total <= total + 1'b1;
            end
        end
    end

    // Strict compare keeps the lowest index on ties
    always_ff @(posedge CLK_i or negedge RST_i) begin
        if (!RST_i) begin
            scan_idx <= '0;
            best_idx <= '0;
            best_cnt <= '0;
        end else if (state == SCAN) begin
            scan_idx <= scan_idx + 1'b1;
            if (cnt[scan_idx] > best_cnt) begin
                best_cnt <= cnt[scan_idx];
                best_idx <= scan_idx;
            end
        end else if (state == ACCUM) begin
            scan_idx <= '0;
            best_idx <= '0;
            best_cnt <= '0;
        end
    end

    always_ff @(posedge CLK_i or negedge RST_i) begin
        if (!RST_i) begin
            bus.m_valid_o      <= 1'b0;
            bus.mode_o         <= '0;
            bus.max_cnt_o      <= '0;
            bus.left_cnt_o     <= '0;
            bus.right_cnt_o    <= '0;
            bus.acc_interval_o <= '0;
        end else if (bus.clear_i) begin
            bus.m_valid_o <= 1'b0;
        end else if (state == NEIGH) begin
            bus.m_valid_o      <= 1'b1;
            bus.mode_o         <= best_idx;
            bus.max_cnt_o      <= best_cnt;
            bus.left_cnt_o     <= (best_idx == '0) ? '0 : cnt[best_idx - 1'b1];
            bus.right_cnt_o    <= (best_idx == LAST_IDX) ? '0 : cnt[best_idx + 1'b1];
            bus.acc_interval_o <= total;
        end else if (drain) begin
            bus.m_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dal_interval_mode_unit.sv
// Bench for dal_interval_mode_unit: a histogram model predicts each block result into a queue
// that is popped when the DUT presents the result.
module tb_dal_interval_mode_unit;
    localparam int SW = 16;
    localparam int NI = 16;
    localparam int CW = 4;
    localparam int AW = 20;
    localparam int IW = 4;
    localparam int RW = IW + 3 * CW + AW;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;
    int         checks = 0;
    int         errors = 0;

    logic [RW-1:0] exp_q[$];
    logic [CW-1:0] m_cnt [NI];
    logic [AW-1:0] m_tot;

    dal_interval_mode_if #(.SCORE_W(SW), .NUM_INT(NI), .CNT_W(CW), .ACC_W(AW)) bus ();

    dal_interval_mode_unit #(.SCORE_W(SW), .NUM_INT(NI), .CNT_W(CW), .ACC_W(AW)) dut (
        .CLK_i    (clk),
        .RST_i    (rst_n),
        .bus      (bus.slave),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        for (int i = 0; i < NI; i++) m_cnt[i] = '0;
        m_tot = '0;
    endfunction

    function automatic void model_take(logic [SW-1:0] s);
        logic [IW-1:0] k;
        k = s[SW-1 -: IW];
        if (m_cnt[k] != {CW{1'b1}}) m_cnt[k] = m_cnt[k] + 1'b1;
        if (m_tot != {AW{1'b1}}) m_tot = m_tot + 1'b1;
    endfunction

    function automatic logic [RW-1:0] model_result();
        int            bi;
        logic [CW-1:0] best, l, r;
        bi = 0;
        best = '0;
        for (int i = 0; i < NI; i++) begin
            if (m_cnt[i] > best) begin
                best = m_cnt[i];
                bi = i;
            end
        end
        l = (bi == 0) ? '0 : m_cnt[bi-1];
        r = (bi == NI - 1) ? '0 : m_cnt[bi+1];
        return {IW'(bi), best, l, r, m_tot};
    endfunction

    task automatic send(input logic [SW-1:0] s, input logic last);
        int w;
        w = 0;
        @(negedge clk);
        bus.s_valid_i = 1'b1;
        bus.score_i   = s;
        bus.last_i    = last;
        while (!bus.s_ready_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.s_ready_o) begin
            checks++;
            errors++;
            $display("FAIL send_ready: s_ready_o=%0b required 1 within 50 cycles", bus.s_ready_o);
        end else begin
            model_take(s);
            if (last) begin
                exp_q.push_back(model_result());
                model_clear();
            end
        end
        @(posedge clk);
        #1;
        bus.s_valid_i = 1'b0;
        bus.last_i    = 1'b0;
    endtask

    task automatic send_block(input logic [SW-1:0] s, input int n, input logic last_on_end);
        for (int i = 0; i < n; i++) send(s, last_on_end && (i == n - 1));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.m_valid_o && n < 100);
        if (!bus.m_valid_o) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: m_valid_o=0 after %0d cycles, required 1", n);
        end
    endtask

    // Scoreboard pop: compare the presented result, optionally hold it under back-pressure, then consume it
    task automatic drain_result(input int bp_cycles);
        logic [RW-1:0] e, got;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL drain_empty: result presented with no expected entry queued");
            return;
        end
        e = exp_q[0];
        got = {bus.mode_o, bus.max_cnt_o, bus.left_cnt_o, bus.right_cnt_o, bus.acc_interval_o};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL result: got mode=%0d max=%0d left=%0d right=%0d acc=%0d required mode=%0d max=%0d left=%0d right=%0d acc=%0d",
                     got[RW-1 -: IW], got[3*CW+AW-1 -: CW], got[2*CW+AW-1 -: CW], got[CW+AW-1 -: CW], got[AW-1:0],
                     e[RW-1 -: IW], e[3*CW+AW-1 -: CW], e[2*CW+AW-1 -: CW], e[CW+AW-1 -: CW], e[AW-1:0]);
        end
        for (int c = 0; c < bp_cycles; c++) begin
            @(negedge clk);
            bus.s_valid_i = 1'($urandom_range(0, 1));
            bus.score_i   = SW'($urandom_range(0, 16'hFFFF));
            bus.last_i    = 1'($urandom_range(0, 1));
            #1;
            got = {bus.mode_o, bus.max_cnt_o, bus.left_cnt_o, bus.right_cnt_o, bus.acc_interval_o};
            checks++;
            if (got !== e || bus.m_valid_o !== 1'b1 || bus.s_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cycle %0d: got %h valid=%0b ready=%0b required %h valid=1 ready=0",
                         c, got, bus.m_valid_o, bus.s_ready_o, e);
            end
        end
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        bus.last_i    = 1'b0;
        bus.m_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.m_ready_i = 1'b0;
        void'(exp_q.pop_front());
        checks++;
        if (bus.m_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL consume: valid=%0b busy=%0b required valid=0 busy=0", bus.m_valid_o, bus.busy_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.m_valid_o, bus.s_ready_o, bus.busy_o, bus.mode_o, bus.max_cnt_o, bus.left_cnt_o,
             bus.right_cnt_o, bus.acc_interval_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b ready=%0b busy=%0b mode=%0d max=%0d acc=%0d required all 0",
                     bus.m_valid_o, bus.s_ready_o, bus.busy_o, bus.mode_o, bus.max_cnt_o, bus.acc_interval_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.s_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_held: s_ready_o=%0b required 0", bus.s_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.s_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%0b busy=%0b required ready=1 busy=0", bus.s_ready_o, bus.busy_o);
        end
    endtask

    task automatic test_basic();
        int n;
        send_block(16'h3000, 3, 1'b0);
        send_block(16'h7000, 5, 1'b0);
        send_block(16'h8000, 2, 1'b1);
        wait_valid(n);
        checks++;
        if (n !== 17) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles required 17", n);
        end
        checks++;
        if (bus.mode_o !== 4'd7 || bus.max_cnt_o !== 4'd5 || bus.left_cnt_o !== 4'd0 ||
            bus.right_cnt_o !== 4'd2 || bus.acc_interval_o !== 20'd10) begin
            errors++;
            $display("FAIL basic_values: mode=%0d max=%0d left=%0d right=%0d acc=%0d required 7 5 0 2 10",
                     bus.mode_o, bus.max_cnt_o, bus.left_cnt_o, bus.right_cnt_o, bus.acc_interval_o);
        end
        drain_result(0);
    endtask

    task automatic test_reset_mid_scan();
        int n;
        send_block(16'h5000, 3, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL midscan_busy: busy=%0b required 1", bus.busy_o);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.m_valid_o, bus.s_ready_o, bus.busy_o, bus.mode_o, bus.max_cnt_o, bus.left_cnt_o,
             bus.right_cnt_o, bus.acc_interval_o} !== '0) begin
            errors++;
            $display("FAIL midscan_reset: valid=%0b ready=%0b busy=%0b mode=%0d max=%0d right=%0d acc=%0d required all 0",
                     bus.m_valid_o, bus.s_ready_o, bus.busy_o, bus.mode_o, bus.max_cnt_o, bus.right_cnt_o,
                     bus.acc_interval_o);
        end
        exp_q.delete();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        send_block(16'h9000, 2, 1'b1);
        wait_valid(n);
        checks++;
        if (bus.mode_o !== 4'd9 || bus.max_cnt_o !== 4'd2 || bus.acc_interval_o !== 20'd2) begin
            errors++;
            $display("FAIL after_reset_block: mode=%0d max=%0d acc=%0d required 9 2 2",
                     bus.mode_o, bus.max_cnt_o, bus.acc_interval_o);
        end
        drain_result(0);
    endtask

    task automatic test_tie_and_edge();
        int n;
        send_block(16'h1000, 4, 1'b0);
        send_block(16'hE000, 4, 1'b1);
        wait_valid(n);
        checks++;
        if (bus.mode_o !== 4'd1 || bus.max_cnt_o !== 4'd4) begin
            errors++;
            $display("FAIL tie: mode=%0d max=%0d required 1 4", bus.mode_o, bus.max_cnt_o);
        end
        drain_result(0);
        send_block(16'hF000, 3, 1'b1);
        wait_valid(n);
        checks++;
        if (bus.mode_o !== 4'd15 || bus.right_cnt_o !== 4'd0 || bus.max_cnt_o !== 4'd3) begin
            errors++;
            $display("FAIL top_edge: mode=%0d right=%0d max=%0d required 15 0 3",
                     bus.mode_o, bus.right_cnt_o, bus.max_cnt_o);
        end
        drain_result(0);
    endtask

    task automatic test_saturation();
        int n;
        send_block(16'h0000, 20, 1'b1);
        wait_valid(n);
        checks++;
        if (bus.mode_o !== 4'd0 || bus.max_cnt_o !== 4'd15 || bus.acc_interval_o !== 20'd20 ||
            bus.left_cnt_o !== 4'd0) begin
            errors++;
            $display("FAIL saturation: mode=%0d max=%0d left=%0d acc=%0d required 0 15 0 20",
                     bus.mode_o, bus.max_cnt_o, bus.left_cnt_o, bus.acc_interval_o);
        end
        drain_result(0);
    endtask

    task automatic test_backpressure();
        int n;
        for (int i = 0; i < 12; i++) send(SW'($urandom_range(0, 16'hFFFF)), i == 11);
        wait_valid(n);
        drain_result(10);
        send(16'hA000, 1'b1);
        wait_valid(n);
        checks++;
        if (bus.mode_o !== 4'd10 || bus.max_cnt_o !== 4'd1 || bus.acc_interval_o !== 20'd1) begin
            errors++;
            $display("FAIL after_backpressure: mode=%0d max=%0d acc=%0d required 10 1 1",
                     bus.mode_o, bus.max_cnt_o, bus.acc_interval_o);
        end
        drain_result(0);
    endtask

    task automatic test_clear();
        int n;
        send_block(16'h2000, 3, 1'b0);
        @(negedge clk);
        bus.s_valid_i = 1'b1;
        bus.score_i   = 16'h4000;
        bus.clear_i   = 1'b1;
        @(posedge clk);
        #1;
        bus.s_valid_i = 1'b0;
        bus.clear_i   = 1'b0;
        model_clear();
        send_block(16'h4000, 2, 1'b1);
        wait_valid(n);
        checks++;
        if (bus.mode_o !== 4'd4 || bus.max_cnt_o !== 4'd2 || bus.acc_interval_o !== 20'd2) begin
            errors++;
            $display("FAIL clear_accum: mode=%0d max=%0d acc=%0d required 4 2 2",
                     bus.mode_o, bus.max_cnt_o, bus.acc_interval_o);
        end
        drain_result(0);
        send_block(16'h6000, 2, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.clear_i = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_i = 1'b0;
        void'(exp_q.pop_back());
        checks++;
        if (bus.busy_o !== 1'b0 || bus.m_valid_o !== 1'b0 || bus.s_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL clear_scan: busy=%0b valid=%0b ready=%0b required 0 0 1",
                     bus.busy_o, bus.m_valid_o, bus.s_ready_o);
        end
    endtask

    task automatic test_back_to_back();
        int n, len;
        for (int b = 0; b < 6; b++) begin
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) send(SW'($urandom_range(0, 16'hFFFF)), i == len - 1);
            wait_valid(n);
            checks++;
            if (n !== NI + 1) begin
                errors++;
                $display("FAIL b2b_latency block %0d: got %0d required %0d", b, n, NI + 1);
            end
            drain_result($urandom_range(0, 3));
        end
    endtask

    initial begin
        bus.clear_i   = 1'b0;
        bus.s_valid_i = 1'b0;
        bus.score_i   = '0;
        bus.last_i    = 1'b0;
        bus.m_ready_i = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_reset_mid_scan();
        test_tie_and_edge();
        test_saturation();
        test_backpressure();
        test_clear();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
